// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : PC register and run/halt/single-step sequencer for the 24-bit CPU.
//               Optional breakpoint compare is enabled by defining BREAKPOINT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter logic [23:0] RESET_VECTOR = 24'd0,
    parameter logic [23:0] PC_INC       = 24'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    input  logic        step,
    input  logic        stall,
    input  logic        branch,
    input  logic [23:0] branch_target,
    input  logic        jump,
    input  logic [23:0] jump_target,
`ifdef BREAKPOINT_EN
    input  logic        bp_valid,
    input  logic [23:0] bp_addr,
    output logic        bp_hit,
`endif
    output logic [23:0] pc,
    output logic        running,
    output logic [23:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [23:0] COUNT_MAX = 24'hFFFFFF;

    state_t      state;
    state_t      state_next;
    logic        step_pending;
    logic        pending_next;
    logic        do_update;
    logic [23:0] next_pc;

`ifdef BREAKPOINT_EN
    logic        bp_bypass;
    logic        bypass_next;
    logic        hit_next;
    logic        bp_match;

    // Bypass lets the first update after a resume leave the breakpoint address.
    assign bp_match = bp_valid && (pc == bp_addr) && !bp_bypass;
`endif

    assign next_pc = jump   ? jump_target   :
                     branch ? branch_target :
                              pc + PC_INC;

    assign running = (state == S_RUN);

    always_comb begin
        state_next   = state;
        pending_next = step_pending;
        do_update    = 1'b0;
`ifdef BREAKPOINT_EN
        bypass_next  = bp_bypass;
        hit_next     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start && !halt) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_next = S_HALTED;
`ifdef BREAKPOINT_EN
                end else if (bp_match) begin
                    state_next = S_HALTED;
                    hit_next   = 1'b1;
`endif
                end else if (!stall) begin
                    do_update = 1'b1;
                end
            end
            S_HALTED: begin
                if (start && !halt) begin
                    state_next   = S_RUN;
                    pending_next = 1'b0;
`ifdef BREAKPOINT_EN
                    bypass_next  = 1'b1;
`endif
                end else if (step_pending) begin
                    // A step arriving while one is already pending is dropped.
                    if (!stall) begin
                        do_update    = 1'b1;
                        pending_next = 1'b0;
                    end
                end else if (step) begin
                    pending_next = 1'b1;
`ifdef BREAKPOINT_EN
                    bypass_next  = 1'b1;
`endif
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
`ifdef BREAKPOINT_EN
        if (do_update) begin
            bypass_next = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            step_pending <= 1'b0;
            pc           <= RESET_VECTOR;
            instr_count  <= 24'd0;
`ifdef BREAKPOINT_EN
            bp_bypass    <= 1'b0;
            bp_hit       <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            step_pending <= pending_next;
`ifdef BREAKPOINT_EN
            bp_bypass    <= bypass_next;
            bp_hit       <= hit_next;
`endif
            if (do_update) begin
                pc <= next_pc;
                if (instr_count != COUNT_MAX) begin
                    instr_count <= instr_count + 24'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed scoreboard bench for pc_sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halt;
    logic        step;
    logic        stall;
    logic        branch;
    logic [23:0] branch_target;
    logic        jump;
    logic [23:0] jump_target;
    logic [23:0] pc;
    logic        running;
    logic [23:0] instr_count;
    logic        bp_hit;
`ifdef BREAKPOINT_EN
    logic        bp_valid;
    logic [23:0] bp_addr;
`else
    assign bp_hit = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [23:0] pc;
        logic        run;
        logic [23:0] cnt;
        logic        hit;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pc_sequencer #(
        .RESET_VECTOR (24'd0),
        .PC_INC       (24'd3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .halt          (halt),
        .step          (step),
        .stall         (stall),
        .branch        (branch),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
`ifdef BREAKPOINT_EN
        .bp_valid      (bp_valid),
        .bp_addr       (bp_addr),
        .bp_hit        (bp_hit),
`endif
        .pc            (pc),
        .running       (running),
        .instr_count   (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are registered, so the falling edge is a stable sample point.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ({pc, running, instr_count, bp_hit} !== {e.pc, e.run, e.cnt, e.hit}) begin
                errors++;
                $display("FAIL %s: got pc=%h run=%b cnt=%h hit=%b, want pc=%h run=%b cnt=%h hit=%b",
                         e.name, pc, running, instr_count, bp_hit, e.pc, e.run, e.cnt, e.hit);
            end
        end
    end

    task automatic tick_bp(input string name, input logic [23:0] epc, input logic erun,
                           input logic [23:0] ecnt, input logic ehit);
        exp_t e;
        @(posedge clk);
        e.name = name;
        e.pc   = epc;
        e.run  = erun;
        e.cnt  = ecnt;
        e.hit  = ehit;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic tick(input string name, input logic [23:0] epc, input logic erun,
                        input logic [23:0] ecnt);
        tick_bp(name, epc, erun, ecnt, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt = 1'b0; step = 1'b0; stall = 1'b0;
        branch = 1'b0; branch_target = 24'h0; jump = 1'b0; jump_target = 24'h0;
`ifdef BREAKPOINT_EN
        bp_valid = 1'b0; bp_addr = 24'h0;
`endif
        tick("reset", 24'h0, 1'b0, 24'd0);
        rst = 1'b0;

        // IDLE ignores everything except Start; Halt beats Start
        step = 1'b1; branch = 1'b1; branch_target = 24'h30;
        tick("idle_ignore", 24'h0, 1'b0, 24'd0);
        step = 1'b0; branch = 1'b0; start = 1'b1; halt = 1'b1;
        tick("idle_halt_prio", 24'h0, 1'b0, 24'd0);
        halt = 1'b0;
        tick("start", 24'h0, 1'b1, 24'd0);
        start = 1'b0;
        tick("seq1", 24'd3, 1'b1, 24'd1);
        tick("seq2", 24'd6, 1'b1, 24'd2);
        tick("seq3", 24'd9, 1'b1, 24'd3);
        tick("seq4", 24'd12, 1'b1, 24'd4);

        // Jump beats Branch, then Branch alone
        branch = 1'b1; branch_target = 24'h30; jump = 1'b1; jump_target = 24'h60;
        tick("jump_prio", 24'h60, 1'b1, 24'd5);
        jump = 1'b0;
        tick("branch", 24'h30, 1'b1, 24'd6);
        branch = 1'b0;

        rst = 1'b1;
        tick("reset_mid_run", 24'h0, 1'b0, 24'd0);
        rst = 1'b0; start = 1'b1;
        tick("restart", 24'h0, 1'b1, 24'd0);
        start = 1'b0;

        // Wrap-around modulo 2^24
        jump = 1'b1; jump_target = 24'hFFFFFF;
        tick("jump_top", 24'hFFFFFF, 1'b1, 24'd1);
        jump = 1'b0;
        tick("wrap", 24'h000002, 1'b1, 24'd2);
        tick("after_wrap", 24'h000005, 1'b1, 24'd3);

        stall = 1'b1;
        tick("stall1", 24'h5, 1'b1, 24'd3);
        tick("stall2", 24'h5, 1'b1, 24'd3);
        tick("stall3", 24'h5, 1'b1, 24'd3);
        halt = 1'b1;
        tick("halt_stall", 24'h5, 1'b0, 24'd3);
        halt = 1'b0; stall = 1'b0;
        tick("halted_frozen", 24'h5, 1'b0, 24'd3);
        jump = 1'b1; jump_target = 24'h77;
        tick("halted_no_jump", 24'h5, 1'b0, 24'd3);
        jump = 1'b0;

        // Resume: first update lands one edge after the Start edge
        start = 1'b1;
        tick("resume", 24'h5, 1'b1, 24'd3);
        start = 1'b0; jump = 1'b1; jump_target = 24'h9;
        tick("jump9", 24'h9, 1'b1, 24'd4);
        jump = 1'b0;
        tick("to12", 24'd12, 1'b1, 24'd5);
        halt = 1'b1;
        tick("halt12", 24'd12, 1'b0, 24'd5);
        halt = 1'b0;

        // Single step held off by Stall
        step = 1'b1; stall = 1'b1;
        tick("step_stall1", 24'd12, 1'b0, 24'd5);
        step = 1'b0;
        tick("step_stall2", 24'd12, 1'b0, 24'd5);
        stall = 1'b0;
        tick("step_exec", 24'd15, 1'b0, 24'd6);
        tick("step_done", 24'd15, 1'b0, 24'd6);

        // Second Step while pending is dropped
        step = 1'b1;
        tick("step_arm", 24'd15, 1'b0, 24'd6);
        tick("step_drop", 24'd18, 1'b0, 24'd7);
        step = 1'b0;
        tick("step_once", 24'd18, 1'b0, 24'd7);

        // Step+Start with Halt: stays HALTED, the step still executes
        step = 1'b1; start = 1'b1; halt = 1'b1;
        tick("step_start_halt", 24'd18, 1'b0, 24'd7);
        step = 1'b0; start = 1'b0; halt = 1'b0;
        tick("step_after_halt", 24'd21, 1'b0, 24'd8);

        // Step in RUN must not leave a pending step behind
        start = 1'b1;
        tick("resume2", 24'd21, 1'b1, 24'd8);
        start = 1'b0; step = 1'b1;
        tick("run_step_ign", 24'd24, 1'b1, 24'd9);
        step = 1'b0;
        tick("run_on", 24'd27, 1'b1, 24'd10);
        halt = 1'b1;
        tick("halt27", 24'd27, 1'b0, 24'd10);
        halt = 1'b0;
        tick("no_stale_step", 24'd27, 1'b0, 24'd10);
        start = 1'b1; halt = 1'b1;
        tick("halted_halt_prio", 24'd27, 1'b0, 24'd10);
        start = 1'b0; halt = 1'b0;

`ifdef BREAKPOINT_EN
        rst = 1'b1;
        tick("bp_reset", 24'h0, 1'b0, 24'd0);
        rst = 1'b0; bp_valid = 1'b1; bp_addr = 24'h9; start = 1'b1;
        tick_bp("bp_start", 24'h0, 1'b1, 24'd0, 1'b0);
        start = 1'b0;
        tick_bp("bp_run3", 24'd3, 1'b1, 24'd1, 1'b0);
        tick_bp("bp_run6", 24'd6, 1'b1, 24'd2, 1'b0);
        tick_bp("bp_run9", 24'd9, 1'b1, 24'd3, 1'b0);
        tick_bp("bp_hit", 24'd9, 1'b0, 24'd3, 1'b1);
        tick_bp("bp_pulse_end", 24'd9, 1'b0, 24'd3, 1'b0);
        start = 1'b1;
        tick_bp("bp_resume", 24'd9, 1'b1, 24'd3, 1'b0);
        start = 1'b0;
        tick_bp("bp_leave", 24'd12, 1'b1, 24'd4, 1'b0);
        tick_bp("bp_run15", 24'd15, 1'b1, 24'd5, 1'b0);
        bp_valid = 1'b0;
`endif

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
